spm_serial_mult: RTL and testbench

- Sequential serial-parallel multiplier datapath built from a chain of WIDTH carry-save bit cells. The per-cell half-sum/full-sum logic is the logic partitioned and equivalence-checked per cell.
- Block adds the upstream operand load/serialiser and the downstream product deserialiser, with valid/ready handshakes on both sides.
- Sits between the operand source (x parallel, y serialised internally) and the product consumer.

---
 rtl/spm_serial_mult.sv | 174 +++++++++++++++++
 tb/tb_spm_serial_mult.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_serial_mult.sv
// spm_serial_mult: serial-parallel multiplier built from a chain of WIDTH
// carry-save bit cells. x is held in parallel. y is shifted out LSB-first,
// one bit per step. Each step produces one product bit, LSB first. A job
// takes 2*WIDTH steps, so the full 2*WIDTH-bit product comes out.
//
// Optional build macro: SPM_ACCUM_EN
//   Adds the acc_clr input and a p_base accumulator.
//   Each result becomes p_base + x*y, modulo 2^(2*WIDTH).
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   in_ready is high only in IDLE. out_valid is high only in DONE.
//   While out_valid is high and out_ready is low, p is held stable.
//   The block does not accept a new operand pair in the same cycle that it
//   hands off a product. Each side therefore gets one idle cycle between jobs.

// One carry-save cell: full-adder sum and majority carry.
module spm_bit_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module spm_serial_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SPM_ACCUM_EN
  input  logic               acc_clr,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(2 * WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(PW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] carry_reg;
  // Cell 0's sum is the newest product bit. It is kept as the MSB of p_sh
  // rather than in a separate flop. Only cells 1..WIDTH-1 keep their own
  // sum register.
  logic [WIDTH-1:1] sum_reg;
  // Holds the 2*WIDTH-1 most recent product bits.
  // The final bit is appended combinationally on the last step.
  logic [PW-2:0]    p_sh;
  logic [CNT_W-1:0] cnt;

  logic             ybit;
  logic [WIDTH-1:0] a_vec;
  logic [WIDTH-1:0] b_vec;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] carry_nxt;
  logic [PW-1:0]    prod_full;
  logic [PW-1:0]    p_next;
  logic             last_step;

  assign ybit  = y_sh[0];
  assign a_vec = x_reg & {WIDTH{ybit}};
  // The top cell has no upstream sum, so its b input is 0.
  assign b_vec = {1'b0, sum_reg};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    spm_bit_cell u_cell (
      .a  (a_vec[i]),
      .b  (b_vec[i]),
      .c  (carry_reg[i]),
      .s  (sum_nxt[i]),
      .co (carry_nxt[i])
    );
  end

  // The product bit for this step (new sum of cell 0) enters at the top.
  assign prod_full = {sum_nxt[0], p_sh};
  assign last_step = (cnt == LAST_STEP);

`ifdef SPM_ACCUM_EN
  logic [PW-1:0] p_base;
  assign p_next = p_base + prod_full;
`else
  assign p_next = prod_full;
`endif

  // Control FSM and datapath registers, with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_reg     <= '0;
      y_sh      <= '0;
      sum_reg   <= '0;
      carry_reg <= '0;
      p_sh      <= '0;
      cnt       <= '0;
      p         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SPM_ACCUM_EN
      p_base    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_reg     <= x;
            y_sh      <= y;
            sum_reg   <= '0;
            carry_reg <= '0;
            p_sh      <= '0;
            cnt       <= '0;
`ifdef SPM_ACCUM_EN
            if (acc_clr) p_base <= '0;
`endif
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_nxt[WIDTH-1:1];
          carry_reg <= carry_nxt;
          y_sh      <= {1'b0, y_sh[WIDTH-1:1]};
          p_sh      <= prod_full[PW-1:1];
          cnt       <= cnt + CNT_W'(1);
          // All carries have drained by the last step, so p_next is exact.
          if (last_step) begin
            p         <= p_next;
`ifdef SPM_ACCUM_EN
            p_base    <= p_next;
`endif
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_serial_mult.sv
// Testbench for spm_serial_mult at WIDTH=8, using directed vectors.
// When built with SPM_ACCUM_EN, acc_clr defaults high. Plain-multiply tests
// then keep their x*y expectations, and test_accum exercises accumulation.
module tb_spm_serial_mult;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] p;
`ifdef SPM_ACCUM_EN
  logic           acc_clr = 1'b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_edge = 0;
  logic [2*W-1:0] exp_q[$];

  spm_serial_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SPM_ACCUM_EN
    .acc_clr   (acc_clr),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Present an operand pair and wait for the edge that accepts it.
  task automatic send_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input bit hold, output bit ok);
    int guard = 0;
    x = xv;
    y = yv;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    ok = (in_ready === 1'b1);
    @(posedge clk);
    acc_edge = cyc;
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises, with a bounded wait.
  task automatic wait_out(output int n, output bit ok);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ok = (out_valid === 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (p !== 16'h0000) begin n_bad++; $display("FAIL reset_p: got %h want 0000", p); end
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    out_ready = 1'b1;
    send_op(8'h03, 8'h05, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_accept: got %b want 1", ok); end
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_run_flags: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_out(n, ok);
    n_cmp++; if (n != 16) begin n_bad++; $display("FAIL basic_latency: got %0d want 16", n); end
    n_cmp++; if (p !== 16'h000F) begin n_bad++; $display("FAIL basic_p: got %h want 000f", p); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_busy: got %b want 0", busy); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_handoff: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_extremes();
    bit ok;
    int n;
    out_ready = 1'b1;
    send_op(8'hFF, 8'hFF, 1'b0, ok);
    wait_out(n, ok);
    n_cmp++; if (ok !== 1'b1 || p !== 16'hFE01) begin n_bad++; $display("FAIL max_p: got %h (valid %b) want fe01", p, ok); end
    n_cmp++; if (dut.carry_reg !== 8'h00) begin n_bad++; $display("FAIL max_carry_flushed: got %h want 00", dut.carry_reg); end
    tick();
    send_op(8'h00, 8'hAB, 1'b0, ok);
    wait_out(n, ok);
    n_cmp++; if (ok !== 1'b1 || p !== 16'h0000) begin n_bad++; $display("FAIL zero_p: got %h (valid %b) want 0000", p, ok); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    out_ready = 1'b0;
    send_op(8'h12, 8'h34, 1'b0, ok);
    // Noise on the input side while busy must be ignored.
    in_valid = 1'b1;
    x = 8'hFF;
    y = 8'hFF;
    wait_out(n, ok);
    n_cmp++; if (n != 16) begin n_bad++; $display("FAIL bp_latency: got %0d want 16", n); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || p !== 16'h03A8) begin n_bad++; $display("FAIL bp_hold_%0d: got valid=%b p=%h want 1/03a8", i, out_valid, p); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int n;
    out_ready = 1'b1;
    send_op(8'hAA, 8'h55, 1'b0, ok);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (p !== 16'h0000 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_outputs: got p=%h valid=%b busy=%b in_ready=%b want 0000/0/0/1", p, out_valid, busy, in_ready); end
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_pulse: got %b want 0", seen); end
    send_op(8'h02, 8'h07, 1'b0, ok);
    wait_out(n, ok);
    n_cmp++; if (ok !== 1'b1 || p !== 16'h000E) begin n_bad++; $display("FAIL midreset_next_p: got %h (valid %b) want 000e", p, ok); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    int prev_edge = 0;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    logic [2*W-1:0] e;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      xv = W'($urandom_range(0, 255));
      yv = W'($urandom_range(0, 255));
      exp_q.push_back(16'(xv) * 16'(yv));
      send_op(xv, yv, 1'b1, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_%0d: got %b want 1", t, ok); end
      if (t > 0) begin
        n_cmp++; if (acc_edge - prev_edge != 18) begin n_bad++; $display("FAIL b2b_gap_%0d: got %0d want 18", t, acc_edge - prev_edge); end
      end
      prev_edge = acc_edge;
      wait_out(n, ok);
      e = exp_q.pop_front();
      n_cmp++; if (ok !== 1'b1 || p !== e) begin n_bad++; $display("FAIL b2b_p_%0d: got %h (valid %b) want %h", t, p, ok, e); end
    end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef SPM_ACCUM_EN
  task automatic test_accum();
    bit ok;
    int n;
    out_ready = 1'b1;
    acc_clr = 1'b1;
    send_op(8'h10, 8'h10, 1'b0, ok);
    wait_out(n, ok);
    n_cmp++; if (ok !== 1'b1 || p !== 16'h0100) begin n_bad++; $display("FAIL acc_first: got %h want 0100", p); end
    tick();
    acc_clr = 1'b0;
    send_op(8'h02, 8'h03, 1'b0, ok);
    wait_out(n, ok);
    n_cmp++; if (ok !== 1'b1 || p !== 16'h0106) begin n_bad++; $display("FAIL acc_second: got %h want 0106", p); end
    tick();
    send_op(8'hFF, 8'hFF, 1'b0, ok);
    wait_out(n, ok);
    n_cmp++; if (ok !== 1'b1 || p !== 16'hFF07) begin n_bad++; $display("FAIL acc_third: got %h want ff07", p); end
    tick();
    acc_clr = 1'b1;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SPM_ACCUM_EN
    test_accum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
